srl_fifo_ctrl: RTL and testbench
================================

SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the shift-register depth in words (>=2, need not be a power of two).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the almost_full threshold (1..DEPTH).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: the write word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the oldest stored word.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all contents.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: occupancy.
REQ-015 The block SHALL have ports empty, full and almost_full, each output, 1 bit: status flags.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH shift line with no reset and no per-stage load; its only write is a whole-line shift (stage 0 <= in_data, stage k <= stage k-1), enabled by push, so that it is inferable as SRL primitives.
REQ-017 push SHALL equal in_valid & in_ready; pop SHALL equal out_valid & out_ready.
REQ-018 in_ready SHALL equal !full & !flush, from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal !empty; out_data SHALL be stage[count-1] when !empty and all-zero when empty.
REQ-020 The read address SHALL be count-1 and SHALL never exceed DEPTH-1.
REQ-021 On push only, count SHALL increment by 1; on pop only, it SHALL decrement by 1; on push & pop together, count SHALL be unchanged and out_data SHALL show the next-oldest word in the following cycle.
REQ-022 The control FSM SHALL have states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH).
REQ-023 In EMPTY, a push SHALL move the FSM to PARTIAL, or to FULL when DEPTH=1 is excluded by REQ-002; pop SHALL be impossible.
REQ-024 In PARTIAL, count reaching DEPTH SHALL move the FSM to FULL and count reaching 0 SHALL move it to EMPTY.
REQ-025 In FULL, a pop SHALL move the FSM to PARTIAL; push SHALL be impossible because in_ready=0.
REQ-026 empty SHALL be (state==EMPTY), full SHALL be (state==FULL), and almost_full SHALL be (count>=AF_LEVEL); all flags SHALL be registered or decoded from registered state.
REQ-027 Latency SHALL be one cycle: a word pushed at edge N SHALL be visible on out_data with out_valid=1 after edge N when the block was empty.
REQ-028 flush SHALL be synchronous and SHALL have priority over push and pop: the next state SHALL be count=0 and EMPTY; stale storage contents SHALL be unreachable.
REQ-029 Arithmetic on count SHALL saturate: it SHALL never wrap below 0 or above DEPTH under any input combination.

Reset
REQ-030 Asserting rst SHALL immediately force count=0, EMPTY, empty=1, full=0, almost_full=0, out_valid=0, out_data=0 and in_ready=0.
REQ-031 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all contents exactly as flush does; storage itself is not cleared.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3)
REQ-033 Push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full rises at count 3; full=1 and in_ready=0 after the 4th push; out_data=0x11 throughout.
REQ-034 From full, pop 4 times -> out_data 0x11,0x22,0x33,0x44 in order; then empty=1, out_data=0x00.
REQ-035 At count=2 holding 0xA1,0xA2, apply simultaneous push 0xA3 and pop -> count stays 2; out_data=0xA2 next cycle, then 0xA3.
REQ-036 At count=3, assert flush together with in_valid and out_ready -> count=0 next cycle; no word is accepted; out_valid=0.
REQ-037 At count=2, assert rst asynchronously between edges -> out_valid=0 and count=0 immediately; push 0x5A after release -> out_data=0x5A, count=1.
REQ-038 Run 10k cycles of random in_valid/out_ready/flush against a reference queue model -> data order matches, count stays within 0..4, and there is no push while full and no pop while empty.

Source files
------------

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: synchronous FIFO whose storage is a plain shift line.
// Each push shifts the whole line by one stage. The oldest word sits at
// stage count-1, so the read address follows the occupancy count.
// A three-state control FSM (EMPTY / PARTIAL / FULL) tracks occupancy,
// and the status flags are decoded from that registered state.
//
// Handshake: a word transfers on either side only in a cycle where
// valid and ready are both high at the rising edge. in_ready depends
// only on registered state and flush, so it has no path from out_ready.
// Once valid is raised, the producer or consumer holds it until the
// transfer.
module srl_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [1:0]                 dbg_state_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rst_done_q;
    logic [WIDTH-1:0] srl_q [DEPTH];
    logic [AW-1:0]   rd_addr;
    logic            push, pop;

    // Status decode and handshakes, all from registered state (plus flush)
    always_comb begin
        empty       = (state_q == ST_EMPTY);
        full        = (state_q == ST_FULL);
        almost_full = (count_q >= CW'(AF_LEVEL));
        in_ready    = rst_done_q & ~full & ~flush;
        out_valid   = ~empty;
        push        = in_valid & in_ready;
        pop         = out_valid & out_ready;
        count       = count_q;
        dbg_state_o = state_q;
    end

    // Read port: the oldest word sits at stage count-1; show zero when empty
    always_comb begin
        rd_addr  = '0;
        out_data = '0;
        if (!empty) begin
            rd_addr  = AW'(count_q - CW'(1));
            out_data = srl_q[rd_addr];
        end
    end

    // Next occupancy and state; flush wins over push and pop
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            count_d = '0;
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        count_d = CW'(1);
                        state_d = ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (push && !pop && (count_q != CW'(DEPTH))) begin
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(DEPTH - 1)) state_d = ST_FULL;
                    end else if (pop && !push && (count_q != '0)) begin
                        count_d = count_q - CW'(1);
                        if (count_q == CW'(1)) state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        count_d = CW'(DEPTH - 1);
                        state_d = ST_PARTIAL;
                    end
                end
                default: begin
                    count_d = '0;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Control registers; reset empties the FIFO the same way flush does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Hold in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done_q <= 1'b0;
        else     rst_done_q <= 1'b1;
    end

    // Shift line: no reset and a single whole-line shift, so it maps to SRLs
    always_ff @(posedge clk) begin
        if (push) begin
            srl_q[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) srl_q[k] <= srl_q[k-1];
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Testbench for srl_fifo_ctrl (WIDTH=8, DEPTH=4, AF_LEVEL=3).
// Directed scenarios come first. A randomized run then follows, checked
// against a reference queue.
module tb_srl_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             flush = 1'b0;
    logic [2:0]       count;
    logic             empty, full, almost_full;
    logic [1:0]       dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_q[$];

    srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b exp 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b exp 0", full); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af got %b exp 0", almost_full); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data got %h exp 00", out_data); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rel_in_ready_early got %b exp 0", in_ready); end
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
            vectors++; if (count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            vectors++; if (almost_full !== ((i + 1) >= AF)) begin miscompares++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1) >= AF); end
            vectors++; if (out_data !== 8'h11) begin miscompares++; $display("FAIL fill_out_data[%0d] got %h exp 11", i, out_data); end
            vectors++; if (full !== (i == 3)) begin miscompares++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 3); end
            vectors++; if (in_ready !== (i != 3)) begin miscompares++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, in_ready, i != 3); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
            vectors++; if (out_data !== vals[i]) begin miscompares++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, vals[i]); end
            tick();
        end
        out_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b exp 1", empty); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL drain_zero got %h exp 00", out_data); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_pre_count got %0d exp 2", count); end
        in_data = 8'hA3; out_ready = 1'b1; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_count got %0d exp 2", count); end
        vectors++; if (out_data !== 8'hA2) begin miscompares++; $display("FAIL b2b_data1 got %h exp a2", out_data); end
        out_ready = 1'b1; tick();
        vectors++; if (out_data !== 8'hA3) begin miscompares++; $display("FAIL b2b_data2 got %h exp a3", out_data); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL b2b_count2 got %0d exp 1", count); end
        tick();
        out_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got %b exp 1", empty); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        in_data = 8'hB3; tick();
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        in_data = 8'hCC; out_ready = 1'b1; flush = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d exp 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL flush_out_data got %h exp 00", out_data); end
        in_valid = 1'b1; in_data = 8'h77; tick();
        in_valid = 1'b0;
        vectors++; if (out_data !== 8'h77) begin miscompares++; $display("FAIL flush_after_data got %h exp 77", out_data); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL flush_after_count got %0d exp 1", count); end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_data = 8'hD1; tick();
        in_data = 8'hD2; tick();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL arst_count got %0d exp 0", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_in_ready got %b exp 0", in_ready); end
        #1;
        rst = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_rel_in_ready got %b exp 1", in_ready); end
        in_valid = 1'b1; in_data = 8'h5A; tick();
        in_valid = 1'b0;
        vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL arst_data got %h exp 5a", out_data); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL arst_count2 got %0d exp 1", count); end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic             exp_rdy, exp_push, exp_pop;
        logic [WIDTH-1:0] exp_data;
        int               sz;
        exp_q.delete();
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 24) == 0);
            in_data   = 8'($urandom_range(0, 255));
            #1;
            sz       = exp_q.size();
            exp_rdy  = (sz < DEPTH) && !flush;
            exp_data = (sz > 0) ? exp_q[0] : 8'h00;
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_in_ready @%0d got %b exp %b", n, in_ready, exp_rdy); end
            vectors++; if (out_valid !== (sz > 0)) begin miscompares++; $display("FAIL rnd_out_valid @%0d got %b exp %b", n, out_valid, sz > 0); end
            vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL rnd_out_data @%0d got %h exp %h", n, out_data, exp_data); end
            vectors++; if (count !== 3'(sz)) begin miscompares++; $display("FAIL rnd_count @%0d got %0d exp %0d", n, count, sz); end
            vectors++; if (count > 3'(DEPTH)) begin miscompares++; $display("FAIL rnd_count_range @%0d got %0d exp <=4", n, count); end
            vectors++; if (empty !== (sz == 0)) begin miscompares++; $display("FAIL rnd_empty @%0d got %b exp %b", n, empty, sz == 0); end
            vectors++; if (full !== (sz == DEPTH)) begin miscompares++; $display("FAIL rnd_full @%0d got %b exp %b", n, full, sz == DEPTH); end
            vectors++; if (almost_full !== (sz >= AF)) begin miscompares++; $display("FAIL rnd_af @%0d got %b exp %b", n, almost_full, sz >= AF); end
            exp_push = in_valid && exp_rdy;
            exp_pop  = (sz > 0) && out_ready;
            tick();
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_pop)  void'(exp_q.pop_front());
                if (exp_push) exp_q.push_back(in_data);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
